// File: rtl/frog_hazard_ctrl_pkg.sv
// ============================================================================
// frog_hazard_ctrl_pkg : shared state encoding, defaults and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package frog_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_EVAL     = 3'd2,
    ST_HIT_HOLD = 3'd3,
    ST_RESPAWN  = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

  localparam int c_def_n_obs      = 3;
  localparam int c_def_cw         = 12;
  localparam int c_def_lives      = 3;
  localparam int c_def_sw         = 8;
  localparam int c_def_goal_y     = 60;
  localparam int c_def_hit_frames = 30;

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frog_hazard_ctrl_if.sv
// ============================================================================
// frog_hazard_ctrl_if : frame strobe, rectangle inputs and game-state outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface frog_hazard_ctrl_if
  import frog_hazard_ctrl_pkg::*;
#(
  parameter int N_OBS = c_def_n_obs,
  parameter int CW    = c_def_cw,
  parameter int LIVES = c_def_lives,
  parameter int SW    = c_def_sw
) ();

  localparam int c_idxw = idx_w(N_OBS);
  localparam int c_lw   = $clog2(LIVES + 1);

  logic                  i_animate;
  logic [N_OBS*CW-1:0]   i_obs_x1;
  logic [N_OBS*CW-1:0]   i_obs_x2;
  logic [N_OBS*CW-1:0]   i_obs_y1;
  logic [N_OBS*CW-1:0]   i_obs_y2;
  logic [CW-1:0]         i_frog_x1;
  logic [CW-1:0]         i_frog_x2;
  logic [CW-1:0]         i_frog_y1;
  logic [CW-1:0]         i_frog_y2;
  logic                  o_hit;
  logic [c_idxw-1:0]     o_hit_idx;
  logic                  o_respawn;
  logic                  o_frozen;
  logic [c_lw-1:0]       o_lives;
  logic [SW-1:0]         o_score;
  logic                  o_game_over;
  logic                  o_frame_done;

  modport master (
    output i_animate, i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2,
    output i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    input  o_hit, o_hit_idx, o_respawn, o_frozen, o_lives, o_score,
    input  o_game_over, o_frame_done
  );

  modport slave (
    input  i_animate, i_obs_x1, i_obs_x2, i_obs_y1, i_obs_y2,
    input  i_frog_x1, i_frog_x2, i_frog_y1, i_frog_y2,
    output o_hit, o_hit_idx, o_respawn, o_frozen, o_lives, o_score,
    output o_game_over, o_frame_done
  );

endinterface

`default_nettype wire

// File: rtl/frog_hazard_ctrl_rect_overlap.sv
// ============================================================================
// frog_hazard_ctrl_rect_overlap : strict rectangle overlap, degenerate never hits
// Rev 1.0
// ============================================================================
`default_nettype none

module frog_hazard_ctrl_rect_overlap #(
  parameter int CW = 12
) (
  input  wire logic [CW-1:0] i_ax1,
  input  wire logic [CW-1:0] i_ax2,
  input  wire logic [CW-1:0] i_ay1,
  input  wire logic [CW-1:0] i_ay2,
  input  wire logic [CW-1:0] i_bx1,
  input  wire logic [CW-1:0] i_bx2,
  input  wire logic [CW-1:0] i_by1,
  input  wire logic [CW-1:0] i_by2,
  output logic               o_overlap
);

  logic w_a_valid;
  logic w_b_valid;
  logic w_cross;

  // Validity must be explicit: an inverted rectangle can still satisfy the edge test.
  assign w_a_valid = (i_ax1 < i_ax2) && (i_ay1 < i_ay2);
  assign w_b_valid = (i_bx1 < i_bx2) && (i_by1 < i_by2);
  assign w_cross   = (i_ax1 < i_bx2) && (i_ax2 > i_bx1) &&
                     (i_ay1 < i_by2) && (i_ay2 > i_by1);
  assign o_overlap = w_a_valid && w_b_valid && w_cross;

endmodule

`default_nettype wire

// File: rtl/frog_hazard_ctrl.sv
// ============================================================================
// frog_hazard_ctrl : per-frame obstacle scan, lives/score and respawn FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module frog_hazard_ctrl
  import frog_hazard_ctrl_pkg::*;
#(
  parameter int N_OBS      = c_def_n_obs,
  parameter int CW         = c_def_cw,
  parameter int LIVES      = c_def_lives,
  parameter int SW         = c_def_sw,
  parameter int GOAL_Y     = c_def_goal_y,
  parameter int HIT_FRAMES = c_def_hit_frames
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  frog_hazard_ctrl_if.slave bus
);

  localparam int c_idxw = idx_w(N_OBS);
  localparam int c_lw   = $clog2(LIVES + 1);
  localparam int c_fcw  = idx_w(HIT_FRAMES);

  state_t              r_state;
  logic [N_OBS*CW-1:0] r_obs_x1;
  logic [N_OBS*CW-1:0] r_obs_x2;
  logic [N_OBS*CW-1:0] r_obs_y1;
  logic [N_OBS*CW-1:0] r_obs_y2;
  logic [CW-1:0]       r_fx1;
  logic [CW-1:0]       r_fx2;
  logic [CW-1:0]       r_fy1;
  logic [CW-1:0]       r_fy2;
  logic [c_idxw-1:0]   r_idx;
  logic                r_found;
  logic [c_idxw-1:0]   r_found_idx;
  logic [c_fcw-1:0]    r_fcnt;
  logic [c_lw-1:0]     r_lives;
  logic [SW-1:0]       r_score;
  logic [c_idxw-1:0]   r_hit_idx;
  logic                r_hit;
  logic                r_respawn;
  logic                r_frozen;
  logic                r_over;
  logic                r_done;

  logic [CW-1:0]       w_ox1 [N_OBS];
  logic [CW-1:0]       w_ox2 [N_OBS];
  logic [CW-1:0]       w_oy1 [N_OBS];
  logic [CW-1:0]       w_oy2 [N_OBS];
  logic                w_overlap;

  for (genvar k = 0; k < N_OBS; k++) begin : g_unpack
    assign w_ox1[k] = r_obs_x1[k*CW +: CW];
    assign w_ox2[k] = r_obs_x2[k*CW +: CW];
    assign w_oy1[k] = r_obs_y1[k*CW +: CW];
    assign w_oy2[k] = r_obs_y2[k*CW +: CW];
  end

  frog_hazard_ctrl_rect_overlap #(.CW(CW)) u_overlap (
    .i_ax1     (r_fx1),
    .i_ax2     (r_fx2),
    .i_ay1     (r_fy1),
    .i_ay2     (r_fy2),
    .i_bx1     (w_ox1[r_idx]),
    .i_bx2     (w_ox2[r_idx]),
    .i_by1     (w_oy1[r_idx]),
    .i_by2     (w_oy2[r_idx]),
    .o_overlap (w_overlap)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_obs_x1    <= '0;
      r_obs_x2    <= '0;
      r_obs_y1    <= '0;
      r_obs_y2    <= '0;
      r_fx1       <= '0;
      r_fx2       <= '0;
      r_fy1       <= '0;
      r_fy2       <= '0;
      r_idx       <= '0;
      r_found     <= 1'b0;
      r_found_idx <= '0;
      r_fcnt      <= '0;
      r_lives     <= c_lw'(LIVES);
      r_score     <= '0;
      r_hit_idx   <= '0;
      r_hit       <= 1'b0;
      r_respawn   <= 1'b0;
      r_frozen    <= 1'b0;
      r_over      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_hit     <= 1'b0;
      r_respawn <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_animate) begin
            r_obs_x1    <= bus.i_obs_x1;
            r_obs_x2    <= bus.i_obs_x2;
            r_obs_y1    <= bus.i_obs_y1;
            r_obs_y2    <= bus.i_obs_y2;
            r_fx1       <= bus.i_frog_x1;
            r_fx2       <= bus.i_frog_x2;
            r_fy1       <= bus.i_frog_y1;
            r_fy2       <= bus.i_frog_y2;
            r_idx       <= '0;
            r_found     <= 1'b0;
            r_found_idx <= '0;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Ascending scan, so the first recorded hit is the lowest index.
          if (w_overlap && !r_found) begin
            r_found     <= 1'b1;
            r_found_idx <= r_idx;
          end
          if (r_idx == c_idxw'(N_OBS - 1)) begin
            r_state <= ST_EVAL;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_EVAL: begin
          r_done <= 1'b1;
          if (r_found) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_found_idx;
            r_lives   <= r_lives - 1'b1;
            if (r_lives == c_lw'(1)) begin
              r_over  <= 1'b1;
              r_state <= ST_OVER;
            end else begin
              r_frozen <= 1'b1;
              r_fcnt   <= '0;
              r_state  <= ST_HIT_HOLD;
            end
          end else if (r_fy1 <= CW'(GOAL_Y)) begin
            if (r_score != {SW{1'b1}}) begin
              r_score <= r_score + 1'b1;
            end
            r_respawn <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HIT_HOLD: begin
          if (bus.i_animate) begin
            if (r_fcnt == c_fcw'(HIT_FRAMES - 1)) begin
              r_frozen  <= 1'b0;
              r_respawn <= 1'b1;
              r_state   <= ST_RESPAWN;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
        ST_RESPAWN: r_state <= ST_IDLE;
        ST_OVER:    r_state <= ST_OVER;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_hit        = r_hit;
  assign bus.o_hit_idx    = r_hit_idx;
  assign bus.o_respawn    = r_respawn;
  assign bus.o_frozen     = r_frozen;
  assign bus.o_lives      = r_lives;
  assign bus.o_score      = r_score;
  assign bus.o_game_over  = r_over;
  assign bus.o_frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_frog_hazard_ctrl.sv
// ============================================================================
// tb_frog_hazard_ctrl : directed checks of scan timing, hits, goals and game over
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frog_hazard_ctrl;

  localparam int N_OBS = 3;
  localparam int CW    = 12;
  localparam int LIVES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;

  frog_hazard_ctrl_if #(.N_OBS(N_OBS), .CW(CW), .LIVES(LIVES), .SW(8)) bus0 ();
  frog_hazard_ctrl_if #(.N_OBS(N_OBS), .CW(CW), .LIVES(LIVES), .SW(2)) bus1 ();

  assign bus1.i_animate = bus0.i_animate;
  assign bus1.i_obs_x1  = bus0.i_obs_x1;
  assign bus1.i_obs_x2  = bus0.i_obs_x2;
  assign bus1.i_obs_y1  = bus0.i_obs_y1;
  assign bus1.i_obs_y2  = bus0.i_obs_y2;
  assign bus1.i_frog_x1 = bus0.i_frog_x1;
  assign bus1.i_frog_x2 = bus0.i_frog_x2;
  assign bus1.i_frog_y1 = bus0.i_frog_y1;
  assign bus1.i_frog_y2 = bus0.i_frog_y2;

  frog_hazard_ctrl #(.N_OBS(N_OBS), .CW(CW), .LIVES(LIVES), .SW(8),
                     .GOAL_Y(60), .HIT_FRAMES(30)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  frog_hazard_ctrl #(.N_OBS(N_OBS), .CW(CW), .LIVES(LIVES), .SW(2),
                     .GOAL_Y(60), .HIT_FRAMES(30)) u_dut_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_obs(input int k, input int x1, input int x2, input int y1, input int y2);
    bus0.i_obs_x1[k*CW +: CW] = CW'(x1);
    bus0.i_obs_x2[k*CW +: CW] = CW'(x2);
    bus0.i_obs_y1[k*CW +: CW] = CW'(y1);
    bus0.i_obs_y2[k*CW +: CW] = CW'(y2);
  endtask

  task automatic set_frog(input int x1, input int x2, input int y1, input int y2);
    bus0.i_frog_x1 = CW'(x1);
    bus0.i_frog_x2 = CW'(x2);
    bus0.i_frog_y1 = CW'(y1);
    bus0.i_frog_y2 = CW'(y2);
  endtask

  task automatic far_obs();
    for (int k = 0; k < N_OBS; k++) set_obs(k, 0, 10, 0, 10);
  endtask

  task automatic pulse_anim();
    bus0.i_animate = 1'b1;
    tick();
    bus0.i_animate = 1'b0;
  endtask

  // Strobe, then land in the cycle where results become visible (N_OBS+2 after strobe).
  task automatic run_frame(input string tag);
    pulse_anim();
    repeat (3) tick();
    chk({tag, "_done_early"}, 32'(bus0.o_frame_done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(bus0.o_frame_done), 32'd1);
  endtask

  initial begin
    bus0.i_animate = 1'b0;
    far_obs();
    set_frog(320, 335, 420, 435);
    repeat (2) tick();

    chk("rst_lives",     32'(bus0.o_lives),      32'd3);
    chk("rst_score",     32'(bus0.o_score),      32'd0);
    chk("rst_hit",       32'(bus0.o_hit),        32'd0);
    chk("rst_hit_idx",   32'(bus0.o_hit_idx),    32'd0);
    chk("rst_respawn",   32'(bus0.o_respawn),    32'd0);
    chk("rst_frozen",    32'(bus0.o_frozen),     32'd0);
    chk("rst_game_over", 32'(bus0.o_game_over),  32'd0);
    chk("rst_done",      32'(bus0.o_frame_done), 32'd0);
    rst = 1'b0;
    tick();

    // Goals with frog top exactly on the line; SW=2 copy saturates at 3.
    set_frog(100, 110, 60, 70);
    for (int g = 1; g <= 4; g++) begin
      run_frame("goal");
      chk("goal_respawn", 32'(bus0.o_respawn), 32'd1);
      chk("goal_hit",     32'(bus0.o_hit),     32'd0);
      chk("goal_score",   32'(bus0.o_score),   32'(g));
      chk("goal_score_sat", 32'(bus1.o_score), (g > 3) ? 32'd3 : 32'(g));
      tick();
      chk("goal_respawn_off", 32'(bus0.o_respawn), 32'd0);
    end
    set_frog(100, 110, 61, 70);
    run_frame("nogoal");
    chk("nogoal_respawn", 32'(bus0.o_respawn), 32'd0);
    chk("nogoal_score",   32'(bus0.o_score),   32'd4);
    tick();

    // Reset during SCAN of a frame that would hit: scan must be dropped.
    set_frog(320, 335, 420, 435);
    set_obs(1, 300, 340, 410, 440);
    pulse_anim();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_lives", 32'(bus0.o_lives), 32'd3);
    chk("midrst_score", 32'(bus0.o_score), 32'd0);
    chk("midrst_hit",   32'(bus0.o_hit),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_done", 32'(bus0.o_frame_done), 32'd0);
    end
    chk("midrst_lives_after", 32'(bus0.o_lives), 32'd3);

    // Shared edge and zero-width frog must not collide.
    set_frog(340, 355, 420, 435);
    run_frame("edge");
    chk("edge_hit",   32'(bus0.o_hit),   32'd0);
    chk("edge_lives", 32'(bus0.o_lives), 32'd3);
    tick();
    set_frog(320, 320, 420, 435);
    run_frame("degen");
    chk("degen_hit", 32'(bus0.o_hit), 32'd0);
    tick();

    // Real overlap with obstacle 1.
    set_frog(320, 335, 420, 435);
    run_frame("hit1");
    chk("hit1_hit",    32'(bus0.o_hit),     32'd1);
    chk("hit1_idx",    32'(bus0.o_hit_idx), 32'd1);
    chk("hit1_lives",  32'(bus0.o_lives),   32'd2);
    chk("hit1_frozen", 32'(bus0.o_frozen),  32'd1);
    tick();
    chk("hit1_pulse_off", 32'(bus0.o_hit),     32'd0);
    chk("hit1_idx_held",  32'(bus0.o_hit_idx), 32'd1);

    for (int i = 0; i < 29; i++) begin
      pulse_anim();
      tick();
    end
    chk("hold29_frozen",  32'(bus0.o_frozen),  32'd1);
    chk("hold29_respawn", 32'(bus0.o_respawn), 32'd0);
    chk("hold29_lives",   32'(bus0.o_lives),   32'd2);
    pulse_anim();
    chk("hold30_respawn", 32'(bus0.o_respawn), 32'd1);
    chk("hold30_frozen",  32'(bus0.o_frozen),  32'd0);
    tick();
    chk("hold30_respawn_off", 32'(bus0.o_respawn), 32'd0);
    tick();

    // Obstacles 0 and 2 overlap a frog that is also on the goal line.
    far_obs();
    set_obs(0, 95, 105, 55, 65);
    set_obs(2, 105, 120, 65, 80);
    set_frog(100, 110, 60, 70);
    run_frame("hit0");
    chk("hit0_hit",     32'(bus0.o_hit),     32'd1);
    chk("hit0_idx",     32'(bus0.o_hit_idx), 32'd0);
    chk("hit0_lives",   32'(bus0.o_lives),   32'd1);
    chk("hit0_score",   32'(bus0.o_score),   32'd0);
    chk("hit0_respawn", 32'(bus0.o_respawn), 32'd0);
    tick();
    for (int i = 0; i < 30; i++) begin
      pulse_anim();
      tick();
    end
    chk("hold2_frozen", 32'(bus0.o_frozen), 32'd0);

    run_frame("hit_last");
    chk("last_hit",       32'(bus0.o_hit),       32'd1);
    chk("last_lives",     32'(bus0.o_lives),     32'd0);
    chk("last_game_over", 32'(bus0.o_game_over), 32'd1);
    chk("last_frozen",    32'(bus0.o_frozen),    32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse_anim();
      repeat (5) begin
        tick();
        chk("over_no_done", 32'(bus0.o_frame_done), 32'd0);
      end
    end
    chk("over_lives",     32'(bus0.o_lives),     32'd0);
    chk("over_game_over", 32'(bus0.o_game_over), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("final_rst_lives", 32'(bus0.o_lives),     32'd3);
    chk("final_rst_over",  32'(bus0.o_game_over), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
